// File: rtl/gfx_cmd_pkg.sv
// Shared definitions for the graphics command decoder: opcodes, field positions
// and the decoded-command record stored in the output FIFO.
package gfx_cmd_pkg;

  localparam int CMD_W   = 52;
  localparam int COORD_W = 10;
  localparam int COLOR_W = 8;
  localparam int OP_W    = 3;

  localparam int OP_MSB  = 51;
  localparam int OP_LSB  = 48;
  localparam int X0_MSB  = 47;
  localparam int X0_LSB  = 38;
  localparam int Y0_MSB  = 37;
  localparam int Y0_LSB  = 28;
  localparam int X1_MSB  = 27;
  localparam int X1_LSB  = 18;
  localparam int Y1_MSB  = 17;
  localparam int Y1_LSB  = 8;
  localparam int COL_MSB = 7;
  localparam int COL_LSB = 0;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PIXEL = 4'd1;
  localparam logic [3:0] OP_LINE  = 4'd2;
  localparam logic [3:0] OP_RECT  = 4'd3;
  localparam logic [3:0] OP_CLEAR = 4'd4;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COLOR_W-1:0] color;
  } dec_cmd_t;

  localparam int DEC_W = $bits(dec_cmd_t);

endpackage

// File: rtl/gfx_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on dout.
// Pointers carry one extra bit so full and empty can be told apart.
module gfx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage holds data only; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/gfx_cmd_decoder.sv
// Decodes 52-bit graphics commands, clamps/sorts coordinates and queues them
// for the rasteriser. Optional GFX_CMD_STATS_EN adds the accepted_cnt port.
module gfx_cmd_decoder
  import gfx_cmd_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [CMD_W-1:0]   cmd,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [OP_W-1:0]    out_op,
  output logic [COORD_W-1:0] out_x0,
  output logic [COORD_W-1:0] out_y0,
  output logic [COORD_W-1:0] out_x1,
  output logic [COORD_W-1:0] out_y1,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef GFX_CMD_STATS_EN
  output logic [15:0]        accepted_cnt,
`endif
  output logic [7:0]         illegal_cnt
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

  function automatic logic [COORD_W-1:0] sat_x(input logic [COORD_W-1:0] v);
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [COORD_W-1:0] sat_y(input logic [COORD_W-1:0] v);
    return (v > Y_MAX) ? Y_MAX : v;
  endfunction

  logic [3:0]         op_p0;
  logic [COORD_W-1:0] x0_p0, y0_p0, x1_p0, y1_p0;
  dec_cmd_t           dec_p0;
  logic               legal_p0;
  logic               illegal_p0;
  logic               accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  dec_cmd_t           head_p1;

  // Decode stage: combinational, in front of the FIFO write port.
  assign op_p0 = cmd[OP_MSB:OP_LSB];
  assign x0_p0 = sat_x(cmd[X0_MSB:X0_LSB]);
  assign y0_p0 = sat_y(cmd[Y0_MSB:Y0_LSB]);
  assign x1_p0 = sat_x(cmd[X1_MSB:X1_LSB]);
  assign y1_p0 = sat_y(cmd[Y1_MSB:Y1_LSB]);

  always_comb begin
    dec_p0       = '0;
    dec_p0.op    = op_p0[OP_W-1:0];
    dec_p0.color = cmd[COL_MSB:COL_LSB];
    legal_p0     = 1'b0;
    illegal_p0   = 1'b0;
    case (op_p0)
      OP_NOP: ;
      OP_PIXEL: begin
        legal_p0  = 1'b1;
        dec_p0.x0 = x0_p0;
        dec_p0.y0 = y0_p0;
        dec_p0.x1 = x0_p0;
        dec_p0.y1 = y0_p0;
      end
      OP_LINE: begin
        legal_p0  = 1'b1;
        dec_p0.x0 = x0_p0;
        dec_p0.y0 = y0_p0;
        dec_p0.x1 = x1_p0;
        dec_p0.y1 = y1_p0;
      end
      OP_RECT: begin
        legal_p0  = 1'b1;
        dec_p0.x0 = (x0_p0 < x1_p0) ? x0_p0 : x1_p0;
        dec_p0.x1 = (x0_p0 < x1_p0) ? x1_p0 : x0_p0;
        dec_p0.y0 = (y0_p0 < y1_p0) ? y0_p0 : y1_p0;
        dec_p0.y1 = (y0_p0 < y1_p0) ? y1_p0 : y0_p0;
      end
      OP_CLEAR: begin
        legal_p0  = 1'b1;
        dec_p0.x0 = '0;
        dec_p0.y0 = '0;
        dec_p0.x1 = X_MAX;
        dec_p0.y1 = Y_MAX;
      end
      default: illegal_p0 = 1'b1;
    endcase
  end

  assign cmd_ready = !full;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && legal_p0;
  assign pop       = out_valid && out_ready;

  // Queue stage: registered head feeds the rasteriser interface.
  gfx_sync_fifo #(
    .WIDTH (DEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .din   (dec_p0),
    .full  (full),
    .pop   (pop),
    .dout  (head_p1),
    .empty (empty)
  );

  // Data lines read as zero whenever nothing is queued, including after reset.
  assign out_valid = !empty;
  assign out_op    = out_valid ? head_p1.op    : '0;
  assign out_x0    = out_valid ? head_p1.x0    : '0;
  assign out_y0    = out_valid ? head_p1.y0    : '0;
  assign out_x1    = out_valid ? head_p1.x1    : '0;
  assign out_y1    = out_valid ? head_p1.y1    : '0;
  assign out_color = out_valid ? head_p1.color : '0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      illegal_cnt <= '0;
    end else if (accept && illegal_p0 && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

`ifdef GFX_CMD_STATS_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      accepted_cnt <= '0;
    end else if (push) begin
      accepted_cnt <= accepted_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gfx_cmd_decoder.sv
// Randomised and directed bench for gfx_cmd_decoder against a queue-based
// reference model built from the command decoding rules.
module tb_gfx_cmd_decoder;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0] op;
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [7:0] color;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [51:0] cmd = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  out_op;
  logic [9:0]  out_x0, out_y0, out_x1, out_y1;
  logic [7:0]  out_color;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  illegal_cnt;
`ifdef GFX_CMD_STATS_EN
  logic [15:0] accepted_cnt;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  int   m_illegal = 0;
  int   m_writes  = 0;
  int   m_drops   = 0;
  int   m_accepts = 0;
  bit   last_acc;

  always #5 clk = ~clk;

  gfx_cmd_decoder dut (
    .clk         (clk),
    .rst_        (rst_),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .out_op      (out_op),
    .out_x0      (out_x0),
    .out_y0      (out_y0),
    .out_x1      (out_x1),
    .out_y1      (out_y1),
    .out_color   (out_color),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef GFX_CMD_STATS_EN
    .accepted_cnt(accepted_cnt),
`endif
    .illegal_cnt (illegal_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [51:0] c);
    exp_t r;
    int op, x0, y0, x1, y1, t;
    op = int'(c[51:48]);
    x0 = int'(c[47:38]);
    y0 = int'(c[37:28]);
    x1 = int'(c[27:18]);
    y1 = int'(c[17:8]);
    if (x0 > 639) x0 = 639;
    if (x1 > 639) x1 = 639;
    if (y0 > 479) y0 = 479;
    if (y1 > 479) y1 = 479;
    if (op == 1) begin
      x1 = x0; y1 = y0;
    end else if (op == 3) begin
      if (x0 > x1) begin t = x0; x0 = x1; x1 = t; end
      if (y0 > y1) begin t = y0; y0 = y1; y1 = t; end
    end else if (op == 4) begin
      x0 = 0; y0 = 0; x1 = 639; y1 = 479;
    end
    r.op = 3'(op);
    r.x0 = 10'(x0);
    r.y0 = 10'(y0);
    r.x1 = 10'(x1);
    r.y1 = 10'(y1);
    r.color = c[7:0];
    return r;
  endfunction

  function automatic logic [51:0] mk(input int op, input int x0, input int y0,
                                     input int x1, input int y1, input int col);
    return {4'(op), 10'(x0), 10'(y0), 10'(x1), 10'(y1), 8'(col)};
  endfunction

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    bit   acc, pp;
    int   op;
    logic [51:0] c;
    exp_t o;
    @(negedge clk);
    chk("cmd_ready", cmd_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() > 0);
    chk("illegal_cnt", illegal_cnt, m_illegal);
`ifdef GFX_CMD_STATS_EN
    chk("accepted_cnt", accepted_cnt, m_writes & 16'hFFFF);
`endif
    if (q.size() > 0) begin
      o = {out_op, out_x0, out_y0, out_x1, out_y1, out_color};
      chk("data", o, q[0]);
    end
    acc = cmd_valid && (q.size() < DEPTH);
    pp  = out_ready && (q.size() > 0);
    c   = cmd;
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) begin
      m_accepts++;
      op = int'(c[51:48]);
      if (op >= 1 && op <= 4) begin
        q.push_back(ref_decode(c));
        m_writes++;
      end else begin
        m_drops++;
        if (op >= 5 && m_illegal < 255) m_illegal++;
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [51:0] c);
    int n = 0;
    cmd = c;
    cmd_valid = 1'b1;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) chk("send_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  function automatic logic [51:0] rnd_cmd();
    logic [51:0] c;
    c[31:0]  = $urandom;
    c[47:32] = 16'($urandom);
    c[51:48] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
    return c;
  endfunction

  initial begin
    exp_t o;
    int   n;
    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_illegal", illegal_cnt, 0);
    chk("rst_data", {out_op, out_x0, out_y0, out_x1, out_y1, out_color}, 0);
    #14 rst_ = 1'b1;
    @(posedge clk); #1;

    // NOP and illegal opcodes are dropped
    out_ready = 1'b1;
    send(mk(0, 1, 2, 3, 4, 5));
    send(mk(7, 1, 2, 3, 4, 5));
    send(mk(15, 1, 2, 3, 4, 5));
    cycle();
    chk("drop_no_valid", out_valid, 0);
    chk("drop_illegal_cnt", illegal_cnt, 2);

    // RECT sort, PIXEL clamp, CLEAR
    send(mk(3, 500, 400, 100, 50, 8'hAB));
    o = {out_op, out_x0, out_y0, out_x1, out_y1, out_color};
    chk("rect", o, {3'd3, 10'd100, 10'd50, 10'd500, 10'd400, 8'hAB});
    send(mk(1, 1000, 700, 3, 3, 8'h22));
    o = {out_op, out_x0, out_y0, out_x1, out_y1, out_color};
    chk("pixel_clamp", o, {3'd1, 10'd639, 10'd479, 10'd639, 10'd479, 8'h22});
    send(mk(4, 5, 6, 7, 8, 8'h11));
    o = {out_op, out_x0, out_y0, out_x1, out_y1, out_color};
    chk("clear", o, {3'd4, 10'd0, 10'd0, 10'd639, 10'd479, 8'h11});
    send(mk(2, 900, 10, 20, 600, 8'h33));
    cycle();

    // Backpressure: four fill the FIFO, fifth waits for the first pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(1, 10 + i, 20 + i, 0, 0, i));
    chk("bp_full", cmd_ready, 0);
    cmd = mk(1, 99, 98, 0, 0, 8'h55);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    o = {out_op, out_x0, out_y0, out_x1, out_y1, out_color};
    chk("bp_hold", o, {3'd1, 10'd10, 10'd20, 10'd10, 10'd20, 8'd0});
    out_ready = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!last_acc && n < 20);
    chk("bp_fifth_cycle", n, 2);
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      cmd = rnd_cmd();
      cmd_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      cycle();
      if (out_valid)
        chk("range", (out_x0 <= 639) && (out_x1 <= 639) && (out_y0 <= 479) && (out_y1 <= 479)
            && (out_op != 3 || (out_x0 <= out_x1 && out_y0 <= out_y1)), 1);
    end
    chk("accepts_sum", m_accepts, m_writes + m_drops);
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Illegal counter saturation
    cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cmd = mk($urandom_range(5, 15), i, i, i, i, i);
      cycle();
    end
    cmd_valid = 1'b0;
    cycle();
    chk("illegal_sat", illegal_cnt, 255);

    // Asynchronous reset with three queued commands
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(2, i, i, i + 1, i + 1, i));
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_ = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_illegal", illegal_cnt, 0);
`ifdef GFX_CMD_STATS_EN
    chk("mid_rst_accepted", accepted_cnt, 0);
`endif
    q.delete();
    m_illegal = 0;
    m_writes = 0;
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cmd = rnd_cmd();
      cmd_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
